// File: rtl/md5_padder.sv
// md5_padder: RFC 1321 padding stage feeding 16-word blocks to the MD5 core, one word per cycle.
// Optional macro MD5_PAD_BYTESWAP_EN: input words are big-endian and are byte-swapped on entry.
module md5_padder #(
  parameter int LEN_W     = 64,
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          in_data_i,
  input  logic                 in_valid_i,
  input  logic                 in_last_i,
  input  logic [2:0]           in_nbytes_i,
  output logic                 in_ready_o,
  output logic [31:0]          out_word_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 out_sob_o,
  output logic                 out_eob_o,
  output logic                 out_eom_o,
  output logic [BLK_CNT_W-1:0] blocks_o
);

  typedef enum logic [2:0] {
    S_DATA,
    S_PAD80,
    S_ZERO,
    S_LEN_LO,
    S_LEN_HI
  } state_t;

  state_t               r_state;
  logic [3:0]           r_idx;
  logic [LEN_W-1:0]     r_bitLen;
  logic                 r_msgDone;
  logic [31:0]          r_word;
  logic                 r_valid;
  logic                 r_sob;
  logic                 r_eob;
  logic                 r_eom;
  logic [BLK_CNT_W-1:0] r_blocks;

  logic                 w_advance;
  logic                 w_accept;
  logic                 w_eobXfer;
  logic [31:0]          w_inWord;
  logic [31:0]          w_lastWord;
  logic [2:0]           w_nbytes;
  logic [63:0]          w_lenExt;
  state_t               w_afterPad;

`ifdef MD5_PAD_BYTESWAP_EN
  assign w_inWord = {in_data_i[7:0], in_data_i[15:8], in_data_i[23:16], in_data_i[31:24]};
`else
  assign w_inWord = in_data_i;
`endif

  assign w_nbytes   = (in_nbytes_i > 3'd4) ? 3'd4 : in_nbytes_i;
  assign w_advance  = !r_valid || out_ready_i;
  assign in_ready_o = (r_state == S_DATA) && w_advance && !rst_i;
  assign w_accept   = in_ready_o && in_valid_i;
  assign w_eobXfer  = r_valid && r_eob && out_ready_i;
  assign w_lenExt   = 64'(r_bitLen);

  // The pad word's own index decides whether the length fits in this block or spills into a new one.
  assign w_afterPad = (r_idx == 4'd13) ? S_LEN_LO : S_ZERO;

  always_comb begin
    w_lastWord = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < w_nbytes) begin
        w_lastWord[8*b +: 8] = w_inWord[8*b +: 8];
      end else if (3'(b) == w_nbytes) begin
        w_lastWord[8*b +: 8] = 8'h80;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_DATA;
      r_idx     <= 4'd0;
      r_bitLen  <= '0;
      r_msgDone <= 1'b0;
      r_word    <= 32'h0;
      r_valid   <= 1'b0;
      r_sob     <= 1'b0;
      r_eob     <= 1'b0;
      r_eom     <= 1'b0;
      r_blocks  <= '0;
    end else begin
      if (w_advance) begin
        r_valid <= 1'b1;
        r_sob   <= (r_idx == 4'd0);
        r_eob   <= (r_idx == 4'd15);
        r_eom   <= 1'b0;
        case (r_state)
          S_DATA: begin
            if (in_valid_i) begin
              r_idx <= r_idx + 4'd1;
              if (in_last_i && (w_nbytes != 3'd4)) begin
                r_word   <= w_lastWord;
                r_bitLen <= r_bitLen + LEN_W'({w_nbytes, 3'b000});
                r_state  <= w_afterPad;
              end else begin
                r_word   <= w_inWord;
                r_bitLen <= r_bitLen + LEN_W'(32);
                if (in_last_i) begin
                  r_state <= S_PAD80;
                end
              end
            end else begin
              r_valid <= 1'b0;
              r_sob   <= 1'b0;
              r_eob   <= 1'b0;
            end
          end
          S_PAD80: begin
            r_word  <= 32'h0000_0080;
            r_idx   <= r_idx + 4'd1;
            r_state <= w_afterPad;
          end
          S_ZERO: begin
            r_word <= 32'h0;
            r_idx  <= r_idx + 4'd1;
            if (r_idx == 4'd13) begin
              r_state <= S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            r_word  <= w_lenExt[31:0];
            r_idx   <= r_idx + 4'd1;
            r_state <= S_LEN_HI;
          end
          S_LEN_HI: begin
            r_word    <= w_lenExt[63:32];
            r_eom     <= 1'b1;
            r_idx     <= r_idx + 4'd1;
            r_bitLen  <= '0;
            r_msgDone <= 1'b1;
            r_state   <= S_DATA;
          end
          default: begin
            r_valid <= 1'b0;
            r_state <= S_DATA;
          end
        endcase
      end

      // The finished message's count stays visible until the next message's first word arrives.
      if (w_accept && r_msgDone) begin
        r_blocks  <= '0;
        r_msgDone <= 1'b0;
      end else if (w_eobXfer && (r_blocks != {BLK_CNT_W{1'b1}})) begin
        r_blocks <= r_blocks + 1'b1;
      end
    end
  end

  assign out_word_o  = r_word;
  assign out_valid_o = r_valid;
  assign out_sob_o   = r_sob;
  assign out_eob_o   = r_eob;
  assign out_eom_o   = r_eom;
  assign blocks_o    = r_blocks;

endmodule

// File: tb/tb_md5_padder.sv
// tb_md5_padder: table-driven, hand-sequenced and randomized checks of md5_padder
// against a byte-level RFC 1321 padding model.
`timescale 1ns/1ps
module tb_md5_padder;

  localparam int LEN_W     = 64;
  localparam int BLK_CNT_W = 16;

  logic                 clk_i;
  logic                 rst_i;
  logic [31:0]          in_data_i;
  logic                 in_valid_i;
  logic                 in_last_i;
  logic [2:0]           in_nbytes_i;
  logic                 in_ready_o;
  logic [31:0]          out_word_o;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic                 out_sob_o;
  logic                 out_eob_o;
  logic                 out_eom_o;
  logic [BLK_CNT_W-1:0] blocks_o;

  md5_padder #(.LEN_W(LEN_W), .BLK_CNT_W(BLK_CNT_W)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_last_i  (in_last_i),
    .in_nbytes_i(in_nbytes_i),
    .in_ready_o (in_ready_o),
    .out_word_o (out_word_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_sob_o  (out_sob_o),
    .out_eob_o  (out_eob_o),
    .out_eom_o  (out_eom_o),
    .blocks_o   (blocks_o)
  );

  typedef struct {
    int          nBytes;
    int          expWords;
    int          padIdx;
    logic [31:0] padWord;
    logic [31:0] lenLo;
    int          blocks;
  } vec_t;

  int           totalChecks  = 0;
  int           passedChecks = 0;
  int           readyMode    = 0;
  byte unsigned msgQ[$];
  logic [34:0]  expQ[$];
  logic [34:0]  gotQ[$];

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: time limit hit with %0d/%0d checks passed, required completion", passedChecks, totalChecks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Transfers are recorded at the falling edge, where valid/ready are settled for the coming rising edge.
  initial forever begin
    @(negedge clk_i);
    if (out_valid_o && out_ready_i && !rst_i)
      gotQ.push_back({out_sob_o, out_eob_o, out_eom_o, out_word_o});
  end

  initial forever begin
    @(posedge clk_i);
    #1;
    if (readyMode == 0) out_ready_i = 1'b1;
    else if (readyMode == 1) out_ready_i = ($urandom_range(0, 99) < 65);
  end

  task automatic checkValue(input string name, input logic [63:0] got, input logic [63:0] exp);
    totalChecks++;
    if (got === exp) passedChecks++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Reference: append 0x80, zero-fill to 56 mod 64, append 64-bit little-endian bit count.
  function automatic void buildExpected();
    byte unsigned    p[$];
    longint unsigned bits;
    int              nWords;
    p = msgQ;
    bits = 64'(msgQ.size()) << 3;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 0; i < 8; i++) p.push_back(8'(bits >> (8 * i)));
    nWords = p.size() / 4;
    expQ.delete();
    for (int w = 0; w < nWords; w++)
      expQ.push_back({(w % 16) == 0, (w % 16) == 15, w == nWords - 1,
                      p[4*w+3], p[4*w+2], p[4*w+1], p[4*w]});
  endfunction

  function automatic logic [34:0] gotAt(input int i);
    if (i >= 0 && i < gotQ.size()) return gotQ[i];
    return 'x;
  endfunction

  task automatic applyStimulus(input int gapPct);
    int          nWords;
    int          nb;
    int          t;
    logic [7:0]  b [4];
    logic [31:0] d;
    nWords = (msgQ.size() + 3) / 4;
    if (nWords == 0) nWords = 1;
    for (int w = 0; w < nWords; w++) begin
      nb = msgQ.size() - 4 * w;
      if (nb > 4) nb = 4;
      for (int k = 0; k < 4; k++) b[k] = (k < nb) ? msgQ[4*w+k] : 8'($urandom);
`ifdef MD5_PAD_BYTESWAP_EN
      d = {b[0], b[1], b[2], b[3]};
`else
      d = {b[3], b[2], b[1], b[0]};
`endif
      while (gapPct > 0 && $urandom_range(0, 99) < gapPct) begin
        @(posedge clk_i);
        #1;
      end
      in_data_i   = d;
      in_valid_i  = 1'b1;
      in_last_i   = (w == nWords - 1);
      in_nbytes_i = (nb == 4) ? 3'(4 + $urandom_range(0, 3)) : 3'(nb);
      t = 0;
      forever begin
        @(negedge clk_i);
        if (in_ready_o) break;
        t++;
        if (t > 2000) begin
          checkValue("acceptTimeout", 64'(in_ready_o), 64'd1);
          break;
        end
      end
      @(posedge clk_i);
      #1;
      in_valid_i  = 1'b0;
      in_data_i   = $urandom;
      in_last_i   = 1'($urandom);
      in_nbytes_i = 3'($urandom);
    end
  endtask

  task automatic waitEom(input string tag);
    bit          seen;
    logic [34:0] lastRec;
    seen = 0;
    for (int t = 0; t < 4000 && !seen; t++) begin
      @(negedge clk_i);
      if (gotQ.size() > 0) begin
        lastRec = gotQ[gotQ.size()-1];
        if (lastRec[32]) seen = 1;
      end
    end
    if (!seen) checkValue({tag, ".eomTimeout"}, 64'(out_eom_o), 64'd1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    int bad;
    int first;
    bad = 0;
    first = -1;
    checkValue({tag, ".wordCount"}, 64'(gotQ.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++)
      if (gotAt(i) !== expQ[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    if (first >= 0)
      $display("[TB] %s first differing word %0d: got %h, model %h", tag, first, gotAt(first), expQ[first]);
    checkValue({tag, ".wordsWrong"}, 64'(bad), 64'd0);
  endtask

  initial begin
    vec_t        vecs [10];
    string       tag;
    logic [34:0] rec;
    int          n;
    bit          found;

    vecs[0] = '{3,   16, 0,  32'h80636261, 32'h018, 1};
    vecs[1] = '{0,   16, 0,  32'h00000080, 32'h000, 1};
    vecs[2] = '{4,   16, 1,  32'h00000080, 32'h020, 1};
    vecs[3] = '{56,  32, 14, 32'h00000080, 32'h1C0, 2};
    vecs[4] = '{55,  16, 13, 32'h80979695, 32'h1B8, 1};
    vecs[5] = '{57,  32, 14, 32'h00008099, 32'h1C8, 2};
    vecs[6] = '{60,  32, 15, 32'h00000080, 32'h1E0, 2};
    vecs[7] = '{63,  32, 15, 32'h809F9E9D, 32'h1F8, 2};
    vecs[8] = '{64,  32, 16, 32'h00000080, 32'h200, 2};
    vecs[9] = '{119, 32, 29, 32'h80D7D6D5, 32'h3B8, 2};

    rst_i       = 1'b1;
    in_data_i   = 32'h0;
    in_valid_i  = 1'b0;
    in_last_i   = 1'b0;
    in_nbytes_i = 3'd0;
    out_ready_i = 1'b1;
    readyMode   = 0;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkValue("reset.outValid", 64'(out_valid_o), 64'd0);
    checkValue("reset.outWord", 64'(out_word_o), 64'd0);
    checkValue("reset.flags", 64'({out_sob_o, out_eob_o, out_eom_o}), 64'd0);
    checkValue("reset.blocks", 64'(blocks_o), 64'd0);
    checkValue("reset.inReady", 64'(in_ready_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkValue("postReset.inReady", 64'(in_ready_o), 64'd1);
    @(posedge clk_i);
    #1;

    for (int v = 0; v < 10; v++) begin
      tag = $sformatf("vec%0d_len%0d", v, vecs[v].nBytes);
      msgQ.delete();
      for (int i = 0; i < vecs[v].nBytes; i++) msgQ.push_back(8'(8'h61 + i));
      buildExpected();
      gotQ.delete();
      applyStimulus(0);
      waitEom(tag);
      checkOutput(tag);
      rec = gotAt(vecs[v].padIdx);
      checkValue({tag, ".padWord"}, 64'(rec[31:0]), 64'(vecs[v].padWord));
      rec = gotAt(vecs[v].expWords - 2);
      checkValue({tag, ".lenLo"}, 64'(rec[31:0]), 64'(vecs[v].lenLo));
      rec = gotAt(vecs[v].expWords - 1);
      checkValue({tag, ".lenHiEobEom"}, 64'(rec[33:0]), 64'h3_0000_0000);
      checkValue({tag, ".blocks"}, 64'(blocks_o), 64'(vecs[v].blocks));
    end

    // Stall the core for three cycles while word 5 is on the output.
    readyMode   = 2;
    out_ready_i = 1'b1;
    msgQ.delete();
    for (int i = 0; i < 40; i++) msgQ.push_back(8'($urandom));
    buildExpected();
    gotQ.delete();
    fork
      applyStimulus(0);
      begin
        found = 0;
        for (int t = 0; t < 500 && !found; t++) begin
          @(posedge clk_i);
          #1;
          if (out_valid_o && gotQ.size() == 5) found = 1;
        end
        if (!found) checkValue("bp.reachWord5", 64'(gotQ.size()), 64'd5);
        out_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk_i);
          checkValue($sformatf("bp.heldWord%0d", k), 64'(out_word_o), 64'(expQ[5][31:0]));
          checkValue($sformatf("bp.inReady%0d", k), 64'(in_ready_o), 64'd0);
          @(posedge clk_i);
          #1;
        end
        out_ready_i = 1'b1;
      end
    join
    waitEom("bp");
    checkOutput("bp");
    checkValue("bp.blocks", 64'(blocks_o), 64'd1);

    // Abort "abc" in its zero fill with a reset pulse, then send it again cleanly.
    readyMode = 0;
    msgQ = '{8'h61, 8'h62, 8'h63};
    buildExpected();
    gotQ.delete();
    applyStimulus(0);
    found = 0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(posedge clk_i);
      #1;
      if (gotQ.size() >= 5) found = 1;
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    checkValue("rst.inReadyDuring", 64'(in_ready_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkValue("rst.outValidAfter", 64'(out_valid_o), 64'd0);
    @(posedge clk_i);
    #1;
    gotQ.delete();
    applyStimulus(0);
    waitEom("rstAbc");
    checkOutput("rstAbc");
    rec = gotAt(0);
    checkValue("rstAbc.word0", 64'(rec[31:0]), 64'h80636261);
    checkValue("rstAbc.blocks", 64'(blocks_o), 64'd1);

    readyMode = 1;
    for (int r = 0; r < 40; r++) begin
      tag = $sformatf("rand%0d", r);
      n = $urandom_range(0, 130);
      msgQ.delete();
      for (int i = 0; i < n; i++) msgQ.push_back(8'($urandom));
      buildExpected();
      gotQ.delete();
      applyStimulus(30);
      waitEom(tag);
      checkOutput(tag);
      checkValue({tag, ".blocks"}, 64'(blocks_o), 64'(expQ.size() / 16));
    end

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
